// File: rtl/mdu_core.sv
// mdu_core: multiply/divide unit owning HI/LO, with a fixed-latency busy window per operation.
// The result is computed at start and held in res_hi/res_lo until the busy window ends.
module mdu_core #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDU_Start,
    input  logic [2:0]  MDU_Op,
    input  logic        MDU_HI_Write,
    input  logic        MDU_LO_Write,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dz_q, dz_d;
    logic        sgn, is_div, valid;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [63:0] prod_s, prod_u, res;
    logic [5:0]  pop;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        sgn    = MDU_Op == 3'd2;
        is_div = MDU_Op == 3'd2 || MDU_Op == 3'd3;
        valid  = MDU_Op <= 3'd4;
        a_mag  = (sgn && A[31]) ? -A : A;
        b_mag  = (sgn && B[31]) ? -B : B;
        b_safe = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (sgn && (A[31] ^ B[31])) ? -q_mag : q_mag;
        rem    = (sgn && A[31]) ? -r_mag : r_mag;
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        pop    = 6'($countones(A ^ B));
        res    = (MDU_Op == 3'd0) ? prod_s :
                 (MDU_Op == 3'd1) ? prod_u :
                 (MDU_Op == 3'd4) ? {58'd0, pop} : {rem, quo};
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == IDLE) begin
            if (MDU_Start) begin
                if (valid) begin
                    state_d  = RUN;
                    cnt_d    = is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                    res_hi_d = res[63:32];
                    res_lo_d = res[31:0];
                    dz_d     = is_div && B == 32'd0;
                end
            end else begin
                hi_d = MDU_HI_Write ? A : hi_q;
                lo_d = MDU_LO_Write ? A : lo_q;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                hi_d    = dz_q ? hi_q : res_hi_q;
                lo_d    = dz_q ? lo_q : res_lo_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy = state_q == RUN;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: table of MDU operations with a scoreboard queue, plus hand sequences for
// divide-by-zero, ignored inputs while busy, and reset during a divide.
module tb_mdu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MDU_Start = 1'b0;
    logic [2:0]  MDU_Op = 3'd0;
    logic        MDU_HI_Write = 1'b0;
    logic        MDU_LO_Write = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO;

    mdu_core dut (
        .clk(clk), .reset(reset), .MDU_Start(MDU_Start), .MDU_Op(MDU_Op),
        .MDU_HI_Write(MDU_HI_Write), .MDU_LO_Write(MDU_LO_Write),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int          total = 0;
    int          pass_cnt = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi, input logic [31:0] lo, input int n);
        exp_t e;
        @(negedge clk);
        chk("idle_before_start", 64'(Busy), 64'd0);
        MDU_Op = op; A = a; B = b; MDU_Start = 1'b1;
        e.hi = hi; e.lo = lo; e.n = n;
        sb.push_back(e);
        @(negedge clk);
        MDU_Start = 1'b0;
    endtask

    task automatic finish_op(input int done);
        int   cnt;
        bit   hold_ok;
        exp_t e;
        cnt = done;
        hold_ok = 1'b1;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (HI !== model_hi || LO !== model_lo) hold_ok = 1'b0;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard: empty at completion");
            return;
        end
        e = sb.pop_front();
        chk("busy_cycles", 64'(cnt), 64'(e.n));
        chk("hold_during_busy", 64'(hold_ok), 64'd1);
        chk("HI", 64'(HI), 64'(e.hi));
        chk("LO", 64'(LO), 64'(e.lo));
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] a);
        @(negedge clk);
        MDU_HI_Write = hw; MDU_LO_Write = lw; A = a;
        @(negedge clk);
        MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0;
        if (hw) model_hi = a;
        if (lw) model_lo = a;
        chk("mt_busy", 64'(Busy), 64'd0);
        chk("mt_HI", 64'(HI), 64'(model_hi));
        chk("mt_LO", 64'(LO), 64'(model_lo));
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4] = '{3'd4, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h00000000, 32'h0000001C, 5};
        vecs[5] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[7] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[8] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_HI", 64'(HI), 64'd0);
        chk("reset_LO", 64'(LO), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n);
            finish_op(0);
        end

        // Divide by zero leaves preloaded HI/LO untouched after the full divide latency.
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        start_op(3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        finish_op(0);

        // Reserved op is a no-op: no busy and HI/LO unchanged.
        @(negedge clk);
        MDU_Op = 3'd6; A = 32'h1234; B = 32'h5; MDU_Start = 1'b1;
        @(negedge clk);
        MDU_Start = 1'b0;
        chk("reserved_busy", 64'(Busy), 64'd0);
        chk("reserved_HI", 64'(HI), 64'(model_hi));
        chk("reserved_LO", 64'(LO), 64'(model_lo));

        // Both writes at once store A in HI and LO.
        mt(1'b1, 1'b1, 32'hABCD0123);

        // mtlo and Start issued mid-mult are ignored.
        start_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        MDU_LO_Write = 1'b1; MDU_Start = 1'b1; MDU_Op = 3'd1; A = 32'h55; B = 32'h3;
        @(negedge clk);
        MDU_LO_Write = 1'b0; MDU_Start = 1'b0;
        finish_op(1);
        @(negedge clk);
        chk("no_late_start_busy", 64'(Busy), 64'd0);
        chk("no_late_mtlo_LO", 64'(LO), 64'd42);

        mt(1'b0, 1'b1, 32'h55);

        // Reset in the middle of a divide aborts with no later HI/LO update.
        start_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_HI", 64'(HI), 64'd0);
        chk("abort_LO", 64'(LO), 64'd0);
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_abort_busy", 64'(Busy), 64'd0);
        chk("post_abort_HI", 64'(HI), 64'd0);
        chk("post_abort_LO", 64'(LO), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
